// File: rtl/paddle_step_sched_if.sv
// Paddle scheduler bus: enable, player direction pulses, paddle positions,
// and the valid/ready update announcement towards the renderer.
// The scheduler connects through the master modport. The decoder and
// renderer side connects through the slave modport.
interface paddle_step_sched_if #(
  parameter int POS_W = 8
);
  logic             enable;
  logic             a_left;
  logic             a_right;
  logic             b_left;
  logic             b_right;
  logic [POS_W-1:0] pos_a;
  logic [POS_W-1:0] pos_b;
  logic             upd_valid;
  logic             upd_player;
  logic             upd_ready;

  modport master (
    input  enable, a_left, a_right, b_left, b_right, upd_ready,
    output pos_a, pos_b, upd_valid, upd_player
  );

  modport slave (
    output enable, a_left, a_right, b_left, b_right, upd_ready,
    input  pos_a, pos_b, upd_valid, upd_player
  );
endinterface

// File: rtl/paddle_step_sched.sv
// paddle_step_sched: accumulates per-player step pulses and time-shares one
// add/clamp unit between the two paddle position registers. A round-robin
// FSM (IDLE -> MOVE -> NOTIFY) selects the player to update. Each position
// change is announced over upd_valid/upd_ready.
// Optional build macro PADDLE_SCHED_COALESCE_EN: when defined, one MOVE
// applies the whole accumulated count instead of a single STEP.
module paddle_step_sched #(
  parameter int POS_W    = 8,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 200,
  parameter int POS_INIT = 100,
  parameter int STEP     = 4,
  parameter int ACC_W    = 3
) (
  input  logic clk,
  input  logic rst,
  paddle_step_sched_if.master bus
);
  // Intermediate widths. IW holds position arithmetic with one carry bit.
  // SW holds the accumulator plus a pulse and a consume without wrapping.
  localparam int IW     = POS_W + 1;
  localparam int SW     = ACC_W + 2;
  localparam int ACC_HI = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_LO = -(1 << (ACC_W - 1));

  localparam logic signed [SW-1:0] ACC_HI_S = SW'(ACC_HI);
  localparam logic signed [SW-1:0] ACC_LO_S = SW'(ACC_LO);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    NOTIFY = 2'd2
  } state_t;

  state_t state, state_next;
  logic   winner, winner_next;   // player owning the add/clamp unit
  logic   rr, rr_next;           // player favoured when both have work

  logic signed [ACC_W-1:0] acc [2];
  logic [POS_W-1:0]        pos [2];
  logic                    left_in [2];
  logic                    right_in [2];
  logic                    consume [2];

  logic signed [ACC_W-1:0] win_acc;
  logic [POS_W-1:0]        win_pos;
  logic [POS_W-1:0]        new_pos;
  logic [IW-1:0]           mag;
  logic [IW-1:0]           delta;
  logic [IW-1:0]           sum_up;
  logic [IW-1:0]           floor_dn;
  logic                    do_move;

  assign left_in[0]  = bus.a_left;
  assign right_in[0] = bus.a_right;
  assign left_in[1]  = bus.b_left;
  assign right_in[1] = bus.b_right;

  assign bus.pos_a = pos[0];
  assign bus.pos_b = pos[1];

  // Shared add/clamp unit for the selected player. In single-step mode it
  // moves by STEP. In coalesce mode it moves by |acc| x STEP.
  always_comb begin
    win_acc = acc[winner];
    win_pos = pos[winner];
`ifdef PADDLE_SCHED_COALESCE_EN
    if (win_acc < 0) begin
      mag = IW'(-SW'(win_acc));
    end else begin
      mag = IW'(SW'(win_acc));
    end
`else
    mag = IW'(1);
`endif
    delta    = mag * IW'(STEP);
    sum_up   = {1'b0, win_pos} + delta;
    floor_dn = IW'(POS_MIN) + delta;
    if (win_acc > 0) begin
      new_pos = (sum_up > IW'(POS_MAX)) ? POS_W'(POS_MAX) : sum_up[POS_W-1:0];
    end else begin
      new_pos = ({1'b0, win_pos} >= floor_dn) ? (win_pos - delta[POS_W-1:0])
                                              : POS_W'(POS_MIN);
    end
    // An acc cancelled between IDLE and MOVE means there is nothing to apply.
    do_move = (state == MOVE) && (win_acc != '0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic signed [ACC_W-1:0] acc_reg;
      logic [POS_W-1:0]        pos_reg;
      logic signed [SW-1:0]    base;
      logic signed [SW-1:0]    sum;
      logic signed [ACC_W-1:0] acc_next;

      assign consume[gi] = do_move && (winner == 1'(gi));
      assign acc[gi]     = acc_reg;
      assign pos[gi]     = pos_reg;

      // Apply the consume first, then add the new pulse, then saturate.
      always_comb begin
        base = SW'(acc_reg);
        if (consume[gi]) begin
`ifdef PADDLE_SCHED_COALESCE_EN
          base = '0;
`else
          base = (acc_reg > 0) ? (base - SW'(1)) : (base + SW'(1));
`endif
        end
        sum = base + $signed(SW'(right_in[gi])) - $signed(SW'(left_in[gi]));
        if (sum > ACC_HI_S) begin
          acc_next = ACC_W'(ACC_HI_S);
        end else if (sum < ACC_LO_S) begin
          acc_next = ACC_W'(ACC_LO_S);
        end else begin
          acc_next = ACC_W'(sum);
        end
      end

      // Pending-step accumulator. It is cleared while the game is stopped.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_reg <= '0;
        end else if (!bus.enable) begin
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_next;
        end
      end

      // Position register. It is written only when this player owns the unit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pos_reg <= POS_W'(POS_INIT);
        end else if (consume[gi]) begin
          pos_reg <= new_pos;
        end
      end
    end
  endgenerate

  // FSM state register, including the latched winner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      winner <= 1'b0;
      rr     <= 1'b0;
    end else begin
      state  <= state_next;
      winner <= winner_next;
      rr     <= rr_next;
    end
  end

  // FSM next-state logic: arbitration, move outcome and handshake completion.
  always_comb begin
    state_next  = state;
    winner_next = winner;
    rr_next     = rr;
    unique case (state)
      IDLE: begin
        if ((acc[0] != '0) && (acc[1] != '0)) begin
          winner_next = rr;
          state_next  = MOVE;
        end else if (acc[0] != '0) begin
          winner_next = 1'b0;
          state_next  = MOVE;
        end else if (acc[1] != '0) begin
          winner_next = 1'b1;
          state_next  = MOVE;
        end
      end
      MOVE: begin
        // A move blocked by the clamp is consumed silently.
        if (do_move && (new_pos != win_pos)) begin
          state_next = NOTIFY;
        end else begin
          state_next = IDLE;
        end
      end
      NOTIFY: begin
        if (bus.upd_ready) begin
          rr_next    = ~winner;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. They decode registered state only, so upd_ready has no
  // combinational path to any output.
  always_comb begin
    bus.upd_valid  = (state == NOTIFY);
    bus.upd_player = winner;
  end
endmodule

// File: tb/tb_paddle_step_sched.sv
// Self-checking bench for paddle_step_sched. A behavioural model written with
// integer arithmetic follows the player rules. The bench compares the DUT
// positions and update handshake to the model every cycle. Directed
// scenarios are followed by randomized pulses, enable and backpressure.
module tb_paddle_step_sched;
  localparam int POS_MIN  = 0;
  localparam int POS_MAX  = 200;
  localparam int POS_INIT = 100;
  localparam int STEP     = 4;
  localparam int ACC_MAX  = 3;
  localparam int ACC_MIN  = -4;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  // Model state: st 0 = waiting, 1 = applying, 2 = announcing.
  int m_acc [2];
  int m_pos [2];
  int m_st;
  int m_w;
  int m_rr;

  paddle_step_sched_if #(.POS_W(8)) bus ();

  paddle_step_sched #(
    .POS_W(8), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_INIT(POS_INIT), .STEP(STEP), .ACC_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc[0] = 0; m_acc[1] = 0;
    m_pos[0] = POS_INIT; m_pos[1] = POS_INIT;
    m_st = 0; m_w = 0; m_rr = 0;
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, and
  // compare all outputs just after the edge.
  task automatic tick(input bit al, input bit ar, input bit bl, input bit br,
                      input bit en, input bit rdy);
    int  d [2];
    bit  cons [2];
    int  a, k, np, base, v;
    bus.a_left = al; bus.a_right = ar;
    bus.b_left = bl; bus.b_right = br;
    bus.enable = en; bus.upd_ready = rdy;
    @(posedge clk);
    d[0] = int'(ar) - int'(al);
    d[1] = int'(br) - int'(bl);
    cons[0] = 1'b0; cons[1] = 1'b0;
    case (m_st)
      0: begin
        if (m_acc[0] != 0 && m_acc[1] != 0) begin m_w = m_rr; m_st = 1; end
        else if (m_acc[0] != 0) begin m_w = 0; m_st = 1; end
        else if (m_acc[1] != 0) begin m_w = 1; m_st = 1; end
      end
      1: begin
        a = m_acc[m_w];
        if (a == 0) begin
          m_st = 0;
        end else begin
`ifdef PADDLE_SCHED_COALESCE_EN
          k = (a < 0) ? -a : a;
`else
          k = 1;
`endif
          if (a > 0) np = (m_pos[m_w] + k * STEP > POS_MAX) ? POS_MAX : m_pos[m_w] + k * STEP;
          else       np = (m_pos[m_w] - k * STEP < POS_MIN) ? POS_MIN : m_pos[m_w] - k * STEP;
          cons[m_w] = 1'b1;
          m_st = (np != m_pos[m_w]) ? 2 : 0;
          m_pos[m_w] = np;
        end
      end
      default: begin
        if (rdy) begin m_rr = 1 - m_w; m_st = 0; end
      end
    endcase
    for (int p = 0; p < 2; p++) begin
      if (!en) begin
        m_acc[p] = 0;
      end else begin
        base = m_acc[p];
        if (cons[p]) begin
`ifdef PADDLE_SCHED_COALESCE_EN
          base = 0;
`else
          base = (m_acc[p] > 0) ? m_acc[p] - 1 : m_acc[p] + 1;
`endif
        end
        v = base + d[p];
        if (v > ACC_MAX) v = ACC_MAX;
        if (v < ACC_MIN) v = ACC_MIN;
        m_acc[p] = v;
      end
    end
    #1;
    check("pos_a", int'(bus.pos_a), m_pos[0]);
    check("pos_b", int'(bus.pos_b), m_pos[1]);
    check("upd_valid", int'(bus.upd_valid), (m_st == 2) ? 1 : 0);
    if (m_st == 2) check("upd_player", int'(bus.upd_player), m_w);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 1, rdy);
  endtask

  // Asynchronous reset away from the clock edge, checked before any edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_pos_a", int'(bus.pos_a), POS_INIT);
    check("rst_pos_b", int'(bus.pos_b), POS_INIT);
    check("rst_upd_valid", int'(bus.upd_valid), 0);
    check("rst_upd_player", int'(bus.upd_player), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    bus.enable = 1'b0; bus.upd_ready = 1'b0;
    bus.a_left = 1'b0; bus.a_right = 1'b0;
    bus.b_left = 1'b0; bus.b_right = 1'b0;
    #2;
    apply_reset();

    // Quiet start: no updates for 50 cycles.
    idle(50, 1);

    // Single step with a fixed latency: pulse, then two edges.
    tick(0, 1, 0, 0, 1, 1);
    idle(2, 1);
    check("lat_pos_a", int'(bus.pos_a), 104);
    check("lat_valid", int'(bus.upd_valid), 1);
    check("lat_player", int'(bus.upd_player), 0);
    idle(3, 1);
    check("lat_valid_drop", int'(bus.upd_valid), 0);

    // Drive paddle B into the upper clamp, then push once more.
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 0, 1, 1, 1);
      idle(3, 1);
    end
    check("clamp_pos_b", int'(bus.pos_b), POS_MAX);
    tick(0, 0, 0, 1, 1, 1);
    idle(6, 1);

    // Fairness: both players step left every cycle.
    for (int i = 0; i < 24; i++) tick(1, 0, 1, 0, 1, 1);
    idle(10, 1);

    // Backpressure: hold the announcement for 10 cycles.
    tick(0, 1, 0, 0, 1, 0);
    idle(2, 0);
    idle(10, 0);
    idle(4, 1);

    // Saturation: five pulses while the unit is busy.
    tick(0, 1, 0, 0, 1, 0);
    idle(2, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 1, 0);
    idle(20, 1);

    // Enable low clears pending steps but not a pending announcement.
    tick(0, 1, 0, 0, 1, 0);
    idle(2, 0);
    tick(0, 1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    idle(5, 1);

    // Reset during an announcement.
    tick(1, 0, 0, 0, 1, 0);
    idle(2, 0);
    apply_reset();
    idle(5, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) != 0), ($urandom_range(0, 2) != 0));
    end
    idle(20, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
